// File: rtl/mealy_rom_pkg.sv
// Shared types and elaboration-time helpers for the ROM-based Mealy counter:
// ROM geometry, the ROM entry builder and the binary-to-Gray converter.
package mealy_rom_pkg;

  // Widest counter supported; the helpers work on this width and callers truncate.
  localparam int MAX_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_COUNT,
    OP_LOAD,
    OP_RESET
  } op_e;

  function automatic int rom_depth(int width);
    return 1 << (width + 1);
  endfunction

  function automatic int rom_width(int width);
    return width + 1;
  endfunction

  // Returns {next[MAX_WIDTH-1:0], tc} for ROM address {state, x}.
  function automatic logic [MAX_WIDTH:0] rom_entry(int state, bit x, int max_count, bit saturate);
    int nxt;
    bit tc;
    nxt = 0;
    tc  = 1'b0;
    if (state <= max_count) begin
      if (x) begin
        tc  = (state == max_count);
        nxt = tc ? (saturate ? max_count : 0) : state + 1;
      end else begin
        tc  = (state == 0);
        nxt = tc ? (saturate ? 0 : max_count) : state - 1;
      end
    end
    return {nxt[MAX_WIDTH-1:0], tc};
  endfunction

  function automatic logic [MAX_WIDTH-1:0] bin2gray(logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/mealy_rom_counter_if.sv
// Control/status bundle of the ROM counter: the master drives the controls,
// the counter (slave) returns the count and the Mealy terminal-count flag.
interface mealy_rom_counter_if #(
  parameter int WIDTH = 3
) ();
  logic             en;
  logic             x;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;

  modport master (output en, x, load, load_val, input count, tc);
  modport slave  (input en, x, load, load_val, output count, tc);
endinterface

// File: rtl/mealy_rom_table.sv
// Combinational ROM lookup: address {state, x} -> data {next, tc}, with the
// contents computed by a constant function at elaboration.
module mealy_rom_table
  import mealy_rom_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = 7,
  parameter int SATURATE  = 0
) (
  input  logic [WIDTH:0]   addr,
  output logic [WIDTH-1:0] next_state,
  output logic             tc
);

  localparam int DEPTH = rom_depth(WIDTH);
  localparam int DW    = rom_width(WIDTH);

  // NOTE: the table is constant wiring, not storage, so it has no reset.
  logic [DW-1:0] rom [DEPTH];

  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    localparam logic [MAX_WIDTH:0] ENTRY = rom_entry(a / 2, (a % 2) == 1, MAX_COUNT, SATURATE != 0);
    assign rom[a] = {ENTRY[WIDTH:1], ENTRY[0]};
  end

  assign {next_state, tc} = rom[addr];

endmodule

// File: rtl/mealy_rom_counter.sv
// Parametrised up/down modulo counter driven by a {state, x} ROM, with wrap or
// saturate, load and a Mealy tc. Define MEALY_ROM_COUNTER_GRAY_EN for Gray count output.
module mealy_rom_counter
  import mealy_rom_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = 7,
  parameter int SATURATE  = 0
) (
  input  logic               clk,
  input  logic               reset,
  mealy_rom_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] rom_next;
  logic             rom_tc;
  op_e              op;

  mealy_rom_table #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .SATURATE  (SATURATE)
  ) u_table (
    .addr       ({state_q, bus.x}),
    .next_state (rom_next),
    .tc         (rom_tc)
  );

  // NOTE: every output of this block gets a default first, so no latch can form.
  always_comb begin
    op      = OP_HOLD;
    state_d = state_q;
    if (reset)         op = OP_RESET;
    else if (bus.load) op = OP_LOAD;
    else if (bus.en)   op = OP_COUNT;
    case (op)
      OP_RESET: state_d = '0;
      OP_LOAD:  state_d = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
      OP_COUNT: state_d = rom_next;
      default:  state_d = state_q;
    endcase
  end

  // NOTE: non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  // tc only predicts a bound crossing on an edge that actually counts.
  assign bus.tc = (op == OP_COUNT) & rom_tc;

`ifdef MEALY_ROM_COUNTER_GRAY_EN
  assign bus.count = WIDTH'(bin2gray(MAX_WIDTH'(state_q)));
`else
  assign bus.count = state_q;
`endif

endmodule

// File: tb/tb_mealy_rom_counter.sv
// Directed bench: a wrap-mode counter (MAX_COUNT=7) and a saturating one
// (MAX_COUNT=5) driven from a vector table, plus a hand-written up-count walk.
module tb_mealy_rom_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a;
  logic reset_b;

  mealy_rom_counter_if #(.WIDTH(3)) bus_a ();
  mealy_rom_counter_if #(.WIDTH(3)) bus_b ();

  mealy_rom_counter #(.WIDTH(3), .MAX_COUNT(7), .SATURATE(0)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a.slave)
  );

  mealy_rom_counter #(.WIDTH(3), .MAX_COUNT(5), .SATURATE(1)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b.slave)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expected count encoding, written independently of the RTL package.
  function automatic logic [2:0] enc(logic [2:0] s);
`ifdef MEALY_ROM_COUNTER_GRAY_EN
    return s ^ {1'b0, s[2:1]};
`else
    return s;
`endif
  endfunction

  typedef struct {
    string      name;
    bit         sel_b;
    bit         rst;
    bit         en;
    bit         x;
    bit         load;
    logic [2:0] lv;
    bit         tc;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, bit sel_b, bit rst, bit en, bit x, bit load,
                              logic [2:0] lv, bit tc, logic [2:0] cnt);
    vec_t v;
    v.name = name; v.sel_b = sel_b; v.rst = rst; v.en = en; v.x = x;
    v.load = load; v.lv = lv; v.tc = tc; v.cnt = cnt;
    return v;
  endfunction

  // The counter not under test is left idle (holding its state).
  task automatic drive(bit sel_b, bit rst, bit en, bit x, bit load, logic [2:0] lv);
    reset_a = sel_b ? 1'b0 : rst;
    bus_a.en = sel_b ? 1'b0 : en;
    bus_a.x = x;
    bus_a.load = sel_b ? 1'b0 : load;
    bus_a.load_val = lv;
    reset_b = sel_b ? rst : 1'b0;
    bus_b.en = sel_b ? en : 1'b0;
    bus_b.x = x;
    bus_b.load = sel_b ? load : 1'b0;
    bus_b.load_val = lv;
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    drive(v.sel_b, v.rst, v.en, v.x, v.load, v.lv);
    #1;
    check({v.name, ".tc"}, v.sel_b ? bus_b.tc : bus_a.tc, v.tc);
    @(posedge clk);
    #1;
    check({v.name, ".count"}, v.sel_b ? bus_b.count : bus_a.count, enc(v.cnt));
  endtask

  logic [2:0] prev;

  initial begin
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    reset_b = 1'b1;

    //                name        B  rst en x  ld lv  tc cnt
    vecs.push_back(mk("a_rst1",   0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("a_rst2",   0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk($sformatf("a_up%0d", i), 0, 0, 1, 1, 0, 0, i == 7, 3'((i + 1) % 8)));
    vecs.push_back(mk("a_dn_wrap", 0, 0, 1, 0, 0, 0, 1, 7));
    vecs.push_back(mk("a_dn6",    0, 0, 1, 0, 0, 0, 0, 6));
    vecs.push_back(mk("a_dn5",    0, 0, 1, 0, 0, 0, 0, 5));
    vecs.push_back(mk("a_rev_up", 0, 0, 1, 1, 0, 0, 0, 6));
    vecs.push_back(mk("a_rev_dn", 0, 0, 1, 0, 0, 0, 0, 5));
    vecs.push_back(mk("a_hold",   0, 0, 0, 1, 0, 0, 0, 5));
    vecs.push_back(mk("a_ld2",    0, 0, 0, 0, 1, 2, 0, 2));
    vecs.push_back(mk("a_ld7",    0, 0, 1, 1, 1, 7, 0, 7));
    vecs.push_back(mk("a_rst_ld", 0, 1, 1, 1, 1, 3, 0, 0));
    vecs.push_back(mk("a_ld_mask",0, 0, 1, 0, 1, 4, 0, 4));
    vecs.push_back(mk("a_mid_rst",0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("a_resume", 0, 0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk("b_rst",    1, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk($sformatf("b_up%0d", i), 1, 0, 1, 1, 0, 0, i >= 5, 3'((i + 1 > 5) ? 5 : i + 1)));
    vecs.push_back(mk("b_ld_clamp", 1, 0, 0, 0, 1, 6, 0, 5));
    vecs.push_back(mk("b_ld2",    1, 0, 0, 0, 1, 2, 0, 2));
    vecs.push_back(mk("b_dn1",    1, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk("b_dn0",    1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("b_sat0a",  1, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk("b_sat0b",  1, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk("b_rst_ld", 1, 1, 0, 0, 1, 4, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Up-count walk across two wraps: each edge must move the count by one
    // code step (exactly one bit in Gray mode).
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    check("walk_reset", bus_a.count, enc(3'd0));
    prev = 3'd0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      @(posedge clk);
      #1;
      check($sformatf("walk_count%0d", i), bus_a.count, enc(3'(i % 8)));
`ifdef MEALY_ROM_COUNTER_GRAY_EN
      check($sformatf("walk_onebit%0d", i), $countones(bus_a.count ^ prev), 1);
`endif
      prev = bus_a.count;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
